// File: rtl/serializer_pkg.sv
// serializer_pkg
// Shared definitions for the nibble serializer slice:
//   state_t   - two-state sequencing FSM encoding (IDLE / SHIFT)
//   sel_width - select width required to address a DATA_W-bit word
package serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Width of a select able to address every bit of a data_w-bit word.
  // A 1-bit floor keeps degenerate widths from producing a zero-width bus.
  function automatic int sel_width(input int data_w);
    return (data_w <= 2) ? 1 : $clog2(data_w);
  endfunction

endpackage

// File: rtl/nibble_serializer_mux_n.sv
// mux_n
// Parameterized DATA_W:1 combinational selector; the generalization of the
// 4:1 mux (d[3:0], s[1:0] -> z) that the serializer feeds.
// Ports:
//   z  output  1       selected bit, d[s]
//   d  input   DATA_W  data inputs
//   s  input   SEL_W   select
module mux_n #(
  parameter int DATA_W = 4,
  parameter int SEL_W  = 2
) (
  output logic              z,
  input  logic [DATA_W-1:0] d,
  input  logic [SEL_W-1:0]  s
);

  // One-hot decode of the select, then an AND-OR reduction; this maps to the
  // same structure a hand-built N:1 mux would use.
  logic [DATA_W-1:0] hit;

  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_decode
    assign hit[gi] = (s == SEL_W'(gi)) & d[gi];
  end

  assign z = |hit;

endmodule

// File: rtl/nibble_serializer.sv
// nibble_serializer
// Accepts a parallel word over a valid/ready handshake, holds it on the mux
// data inputs, and steps the mux select LSB first, holding each select value
// for HOLD_CYCLES clocks. The selected bit is presented as a serial stream
// qualified by ser_valid / ser_last.
// Ports:
//   clk        input   1       rising-edge clock
//   reset      input   1       asynchronous active-high reset
//   in_data    input   DATA_W  parallel word to serialize
//   in_valid   input   1       in_data valid this cycle
//   in_ready   output  1       a word is accepted this cycle if in_valid
//   d_out      output  DATA_W  held word (mux data inputs)
//   sel        output  SEL_W   current select (mux select)
//   ser_out    output  1       d_out[sel]
//   ser_valid  output  1       ser_out meaningful this cycle
//   ser_last   output  1       final hold cycle of bit DATA_W-1
//   busy       output  1       a word is being serialized
module nibble_serializer
  import serializer_pkg::*;
#(
  parameter int DATA_W      = 4,
  parameter int HOLD_CYCLES = 1,
  localparam int SEL_W      = sel_width(DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] d_out,
  output logic [SEL_W-1:0]  sel,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              ser_last,
  output logic              busy
);

  localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(DATA_W - 1);
  localparam logic [7:0]       HOLD_MAX = 8'(HOLD_CYCLES - 1);

  state_t     state;
  logic [7:0] hold;
  logic       hold_done;
  logic       last_cycle;

  assign hold_done  = (hold == HOLD_MAX);
  assign last_cycle = (state == SHIFT) && (sel == SEL_MAX) && hold_done;

  // Status strobes decode straight from the state/counter registers, so they
  // follow an asynchronous reset without waiting for a clock edge.
  assign busy      = (state == SHIFT);
  assign ser_valid = (state == SHIFT);
  assign ser_last  = last_cycle;
  // Ready on the final cycle lets a new word follow with no bubble.
  assign in_ready  = (state == IDLE) || last_cycle;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      d_out <= '0;
      sel   <= '0;
      hold  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            d_out <= in_data;
            sel   <= '0;
            hold  <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (last_cycle) begin
            // Explicit wrap: sel never relies on counter overflow.
            sel  <= '0;
            hold <= '0;
            if (in_valid) begin
              d_out <= in_data;
            end else begin
              state <= IDLE;
            end
          end else if (hold_done) begin
            hold <= '0;
            sel  <= sel + 1'b1;
          end else begin
            hold <= hold + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  mux_n #(
    .DATA_W(DATA_W),
    .SEL_W (SEL_W)
  ) u_mux (
    .z(ser_out),
    .d(d_out),
    .s(sel)
  );

endmodule
